// File: rtl/mem_pkg.sv
// Shared definitions for the RV32I memory stage: FSM states, funct3 encodings,
// exception cause codes and funct3 legality helpers.
package mem_pkg;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_MISAL = 2'b01;
    localparam logic [1:0] EXC_BUS   = 2'b10;
    localparam logic [1:0] EXC_ILL   = 2'b11;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane logic: store byte enables and lane replication, load alignment
// with sign/zero extension. Purely combinational.
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        be    = 4'b1111;
        wdata = rs2;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr;
                wdata = {4{rs2[7:0]}};
            end
            2'b01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rs2[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = rs2;
            end
        endcase
    end

    always_comb begin
        shifted   = rdata >> {addr, 3'b000};
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: EX/MEM and MEM/WB registers, data-memory req/ack
// handshake with wait-state stall and bus timeout.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        VALID_EX,
    input  logic [31:0] ALU_OUT_EX,
    input  logic [31:0] REG_DATA2_EX,
    input  logic [4:0]  RD_EX,
    input  logic [2:0]  Funct3_EX,
    input  logic        MemRd_EX,
    input  logic        MemRW_EX,
    input  logic        RegWEn_EX,
    input  logic [1:0]  WBSel_EX,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [3:0]  DMEM_BE,
    output logic [31:0] DMEM_WDATA,
    input  logic [31:0] DMEM_RDATA,
    input  logic        DMEM_ACK,
    output logic        STALL_MEM,
    output logic        VALID_WB,
    output logic [4:0]  RD_WB,
    output logic        RegWEn_WB,
    output logic [1:0]  WBSel_WB,
    output logic [31:0] ALU_OUT_WB,
    output logic [31:0] MEM_DATA_WB,
    output logic [1:0]  MEM_EXC_WB,
    output state_t      fsm_state
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic        m_valid, m_rd_op, m_wr_op, m_regwen;
    logic [31:0] m_alu, m_rs2;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_wbsel;

    state_t        state;
    logic [CW-1:0] cnt;

    logic        mem_op, illegal, misal, req, abort;
    logic [1:0]  exc;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;

    // Handshake: DMEM_REQ and its companions come from registered state only.
    // An access completes in the cycle where REQ and ACK are both high; ACK
    // while REQ is low has no effect.
    always_comb begin
        mem_op  = m_valid & (m_rd_op | m_wr_op);
        illegal = mem_op & ((m_rd_op & m_wr_op) |
                            (m_rd_op & ~load_f3_ok(m_f3)) |
                            (m_wr_op & ~store_f3_ok(m_f3)));
        misal   = mem_op & (((m_f3[1:0] == 2'b01) & m_alu[0]) |
                            ((m_f3[1:0] == 2'b10) & (m_alu[1:0] != 2'b00)));
        req     = mem_op & ~illegal & ~misal;
        abort   = req & (state == S_WAIT) & ~DMEM_ACK & (cnt == CNT_LAST);
        exc     = EXC_NONE;
        if (illegal)
            exc = EXC_ILL;
        else if (misal)
            exc = EXC_MISAL;
        else if (abort)
            exc = EXC_BUS;
    end

    lsu_align u_align (
        .addr      (m_alu[1:0]),
        .funct3    (m_f3),
        .rs2       (m_rs2),
        .rdata     (DMEM_RDATA),
        .be        (st_be),
        .wdata     (st_wdata),
        .load_data (ld_data)
    );

    assign DMEM_REQ   = req;
    assign DMEM_WE    = req & m_wr_op;
    assign DMEM_ADDR  = {m_alu[31:2], 2'b00};
    assign DMEM_BE    = req ? (m_wr_op ? st_be : 4'b1111) : 4'b0000;
    assign DMEM_WDATA = st_wdata;
    assign STALL_MEM  = req & ~DMEM_ACK & ~abort;
    assign fsm_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (req && !DMEM_ACK) begin
                        state <= S_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                S_WAIT: begin
                    if (DMEM_ACK || cnt == CNT_LAST) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_rd_op  <= 1'b0;
            m_wr_op  <= 1'b0;
            m_regwen <= 1'b0;
            m_alu    <= '0;
            m_rs2    <= '0;
            m_rd     <= '0;
            m_f3     <= '0;
            m_wbsel  <= '0;
        end else if (!STALL_MEM) begin
            m_valid  <= VALID_EX;
            m_rd_op  <= MemRd_EX;
            m_wr_op  <= MemRW_EX;
            m_regwen <= RegWEn_EX;
            m_alu    <= ALU_OUT_EX;
            m_rs2    <= REG_DATA2_EX;
            m_rd     <= RD_EX;
            m_f3     <= Funct3_EX;
            m_wbsel  <= WBSel_EX;
        end
    end

    // A stalled M slot sends a bubble down so WB never sees a half-done access.
    always_ff @(posedge clk) begin
        if (rst || STALL_MEM) begin
            VALID_WB    <= 1'b0;
            RD_WB       <= '0;
            RegWEn_WB   <= 1'b0;
            WBSel_WB    <= '0;
            ALU_OUT_WB  <= '0;
            MEM_DATA_WB <= '0;
            MEM_EXC_WB  <= EXC_NONE;
        end else begin
            VALID_WB    <= m_valid;
            RD_WB       <= m_rd;
            RegWEn_WB   <= m_valid & m_regwen & (exc == EXC_NONE);
            WBSel_WB    <= m_wbsel;
            ALU_OUT_WB  <= m_alu;
            MEM_DATA_WB <= (req && m_rd_op && DMEM_ACK) ? ld_data : 32'h0;
            MEM_EXC_WB  <= exc;
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the RV32I pipeline, directly downstream of the execute stage. Holds the EX/MEM and MEM/WB pipeline registers, drives the data-memory request/acknowledge handshake for loads and stores, and stalls the upstream pipeline while an access is outstanding. Also generates byte enables, lane-replicates store data, aligns and sign/zero-extends load data, and enforces a bus timeout.

## Interface
- TIMEOUT, 16, maximum cycles a request stays outstanding before it is aborted (≥2)
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- VALID_EX  in  1  EX holds a live instruction
- ALU_OUT_EX  in  32  ALU result; effective address for memory ops
- REG_DATA2_EX  in  32  rs2 value (store data)
- RD_EX  in  5  destination register
- Funct3_EX  in  3  access size/sign per RV32I
- MemRd_EX  in  1  load
- MemRW_EX  in  1  store
- RegWEn_EX  in  1  writeback enable
- WBSel_EX  in  2  writeback select, passed through
- DMEM_REQ  out  1  access request
- DMEM_WE  out  1  1 = write
- DMEM_ADDR  out  32  word address, bits [1:0] forced to 0
- DMEM_BE  out  4  byte enables
- DMEM_WDATA  out  32  lane-replicated store data
- DMEM_RDATA  in  32  read word, valid in the ACK cycle
- DMEM_ACK  in  1  access completes this cycle
- STALL_MEM  out  1  freeze EX and earlier stages
- VALID_WB, RD_WB[4:0], RegWEn_WB, WBSel_WB[1:0], ALU_OUT_WB[31:0], MEM_DATA_WB[31:0]  out  MEM/WB register contents
- MEM_EXC_WB  out  2  cause: 00 none, 01 misaligned, 10 bus timeout, 11 illegal op

## Operation
- M register = EX/MEM register. Loaded from the *_EX inputs each cycle when STALL_MEM=0; holds when STALL_MEM=1.
- W register = MEM/WB register. Loaded from M plus load result when the M instruction completes. Loaded with a bubble when M stalls: VALID_WB=0, RegWEn_WB=0, MEM_EXC_WB=00.
- Memory op = M_valid & (MemRd | MemRW).
- Illegal op:
  - MemRd & MemRW both set, or
  - load funct3 ∉ {000,001,010,100,101}, or
  - store funct3 ∉ {000,001,010}.
- Misaligned: halfword op with addr[0]=1, or word op with addr[1:0]≠00.
- Illegal or misaligned ops:
  - No request, no stall; complete in one cycle.
  - W gets cause 11 or 01 respectively; RegWEn_WB=0.
  - Illegal takes priority over misaligned.
- Stores:
  - SB: BE = 0001<<addr[1:0], WDATA = {4{rs2[7:0]}}.
  - SH: BE = addr[1] ? 1100 : 0011, WDATA = {2{rs2[15:0]}}.
  - SW: BE = 1111, WDATA = rs2.
- Loads:
  - BE = 1111.
  - Shifted word = RDATA >> (8·addr[1:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged.
- Non-memory ops: MEM_DATA_WB = 0; ALU_OUT_WB = M ALU result.
- FSM state S_RUN:
  - Legal memory op in M → DMEM_REQ=1.
  - ACK → complete.
  - No ACK → S_WAIT with cnt=1.
- FSM state S_WAIT:
  - REQ, WE, ADDR, BE, WDATA held stable.
  - ACK → complete, go to S_RUN.
  - Otherwise, at cnt=TIMEOUT−1 → abort: REQ drops next cycle, W gets cause 10 with RegWEn_WB=0, go to S_RUN.
  - Otherwise cnt++.
- STALL_MEM = legal memory op in M & ~DMEM_ACK & ~abort (combinational).

## Timing
- Non-memory op and zero-wait access: instruction at EX in cycle n appears at W outputs in cycle n+2.
- k-cycle wait: W outputs in cycle n+2+k.
- DMEM_REQ and its companion signals depend only on registered state (M register, FSM); none combinationally depend on DMEM_ACK.
- ACK sampled only while REQ=1; ACK with REQ=0 is ignored.
- Timeout path: REQ is high for exactly TIMEOUT cycles, then W carries cause 10 on the next edge.
- Reset:
  - Clears M_valid, VALID_WB, RegWEn_WB, MEM_EXC_WB, all data registers to 0; state to S_RUN; cnt to 0.
  - DMEM_REQ=0 and STALL_MEM=0 in the cycle after reset is sampled.
  - Reset mid-wait abandons the access with no ACK required; memory must tolerate a dropped request.
- Back-to-back memory ops: the second is latched into M on the same edge that completes the first, so REQ may stay high continuously with new address/data.

## Structure
- Package mem_pkg holds:
  - FSM state enum (S_RUN, S_WAIT).
  - Funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Cause codes: EXC_NONE, EXC_MISAL, EXC_BUS, EXC_ILL.
- One combinational sub-module, lsu_align: inputs addr[1:0], funct3, rs2, rdata; outputs BE, WDATA, load result.
- FSM, timeout counter and both pipeline registers live in mem_stage.

## Test plan
- SB of rs2=0x000000A5 to addr 0x103, ACK on first REQ cycle → BE=1000, WDATA=0xA5A5A5A5, DMEM_ADDR=0x100, STALL_MEM never high.
- LB from 0x202, RDATA=0x0080FF00, ACK after 3 cycles → STALL_MEM high for exactly 3 cycles, then MEM_DATA_WB=0xFFFFFF80. Repeat as LBU → 0x00000080.
- LW at 0x06 → no REQ, no stall, MEM_EXC_WB=01, RegWEn_WB=0. Load with funct3=011 → MEM_EXC_WB=11.
- Load with ACK never asserted, TIMEOUT=16 → REQ high 16 cycles, then MEM_EXC_WB=10, VALID_WB=1, FSM in S_RUN.
- Back-to-back SW 0x40 then LW 0x40 with 1-cycle wait each → load returns the stored word; W bubbles appear only during wait cycles.
- rst asserted during S_WAIT → next cycle DMEM_REQ=0, STALL_MEM=0, VALID_WB=0; later ACK pulse with REQ=0 is ignored.
